ycbcr_dct_sequencer: RTL and testbench

Sequences the shared RGB→YCbCr→DCT datapath (`rgb2ycbcr_dct`) across the three colour components of one 8x8 block. It does this:
- captures an RGB block from upstream;
- replays it into the datapath once per component, driving a stable `component_sel`;
- registers each DCT result and emits it downstream, tagged with component and block index.

It sits between the block fetcher and the quantizer/entropy stage.

---
 rtl/ycbcr_dct_sequencer_if.sv | 68 ++++++
 rtl/ycbcr_dct_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ycbcr_dct_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr_dct_sequencer_if.sv
// ycbcr_dct_sequencer_if
//   Groups every handshake and bus signal of the YCbCr/DCT sequencer. clk and
//   rst_n are not part of this interface.
//   Signal groups:
//     s_*          upstream RGB block (valid/ready, planar pixels, chroma_en)
//     dp_*         request to and result from the shared rgb2ycbcr_dct datapath
//     m_*          registered DCT result to the quantizer/entropy stage
//     busy         sequencer is working on a block
//     err_timeout  sticky datapath watchdog error
//   Modports:
//     master  the sequencer's view
//     slave   the surrounding environment's view (fetcher, datapath, quantizer)
interface ycbcr_dct_sequencer_if #(
  parameter int INPUT_WIDTH        = 8,
  parameter int PIXEL_COUNT        = 64,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int BLK_IDX_W          = 16
);
  localparam int PixW  = INPUT_WIDTH * PIXEL_COUNT;
  localparam int DataW = 64 * FIXED_POINT_LENGTH;

  logic             s_valid;
  logic             s_ready;
  logic [PixW-1:0]  s_r;
  logic [PixW-1:0]  s_g;
  logic [PixW-1:0]  s_b;
  logic             chroma_en;

  logic             dp_valid;
  logic             dp_ready;
  logic [PixW-1:0]  dp_r;
  logic [PixW-1:0]  dp_g;
  logic [PixW-1:0]  dp_b;
  logic [1:0]       dp_comp_sel;
  logic             dp_out_valid;
  logic             dp_out_ready;
  logic [DataW-1:0] dp_out_data;

  logic                 m_valid;
  logic                 m_ready;
  logic [DataW-1:0]     m_data;
  logic [1:0]           m_comp;
  logic [BLK_IDX_W-1:0] m_blk_idx;
  logic                 m_last;

  logic busy;
  logic err_timeout;

  modport master (
    input  s_valid, s_r, s_g, s_b, chroma_en,
    input  dp_ready, dp_out_valid, dp_out_data,
    input  m_ready,
    output s_ready,
    output dp_valid, dp_r, dp_g, dp_b, dp_comp_sel, dp_out_ready,
    output m_valid, m_data, m_comp, m_blk_idx, m_last,
    output busy, err_timeout
  );

  modport slave (
    output s_valid, s_r, s_g, s_b, chroma_en,
    output dp_ready, dp_out_valid, dp_out_data,
    output m_ready,
    input  s_ready,
    input  dp_valid, dp_r, dp_g, dp_b, dp_comp_sel, dp_out_ready,
    input  m_valid, m_data, m_comp, m_blk_idx, m_last,
    input  busy, err_timeout
  );
endinterface

// File: rtl/ycbcr_dct_sequencer.sv
// ycbcr_dct_sequencer
//   Captures one 8x8 RGB block, replays it into the shared RGB->YCbCr->DCT
//   datapath once per colour component (Y only, or Y/Cb/Cr), registers each
//   DCT result and hands it downstream tagged with component and block index.
//   Ports:
//     clk    clock
//     rst_n  asynchronous, active-low reset
//     bus    ycbcr_dct_sequencer_if.master (upstream s_*, datapath dp_*,
//            downstream m_*, busy, err_timeout)
//   Optional feature: define YCBCR_SEQ_WATCHDOG_EN to abort a component whose
//   datapath request/result takes WDOG_CYCLES cycles; the block is dropped and
//   err_timeout latches. Without it err_timeout is tied low.
module ycbcr_dct_sequencer #(
  parameter int INPUT_WIDTH        = 8,
  parameter int PIXEL_COUNT        = 64,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int BLK_IDX_W          = 16,
  parameter int WDOG_CYCLES        = 1024
) (
  input logic                   clk,
  input logic                   rst_n,
  ycbcr_dct_sequencer_if.master bus
);
  localparam int PixW  = INPUT_WIDTH * PIXEL_COUNT;
  localparam int DataW = 64 * FIXED_POINT_LENGTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_e;

  state_e               state_q, state_d;
  logic [1:0]           comp_q, comp_d;
  logic                 mode_q, mode_d;
  logic [BLK_IDX_W-1:0] blk_idx_q, blk_idx_d;
  logic [PixW-1:0]      pix_r_q, pix_r_d;
  logic [PixW-1:0]      pix_g_q, pix_g_d;
  logic [PixW-1:0]      pix_b_q, pix_b_d;
  logic [DataW-1:0]     m_data_q, m_data_d;
  logic [1:0]           m_comp_q, m_comp_d;
  logic                 last_comp;
  logic                 wdog_expired;

  // mode_q = 1 walks Y, Cb, Cr; mode_q = 0 stops after Y.
  assign last_comp = mode_q ? (comp_q == 2'd2) : (comp_q == 2'd0);

`ifdef YCBCR_SEQ_WATCHDOG_EN
  localparam int WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;

  // Reaching WDOG_CYCLES-1 here means this is the WDOG_CYCLES-th cycle spent
  // in ISSUE/WAIT for the current component.
  assign wdog_expired = ((state_q == ISSUE) || (state_q == WAIT)) &&
                        (wdog_q == WdogW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if ((state_d == ISSUE) && (state_q != ISSUE)) begin
      wdog_d = '0;
    end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
      wdog_d = wdog_q + 1'b1;
    end
    // A handshake in the expiring cycle wins, so only a real abort latches.
    if (wdog_expired && (state_d == IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign bus.err_timeout = err_q;
`else
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = (WDOG_CYCLES != 0);
  assign wdog_expired    = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    comp_d    = comp_q;
    mode_d    = mode_q;
    blk_idx_d = blk_idx_q;
    pix_r_d   = pix_r_q;
    pix_g_d   = pix_g_q;
    pix_b_d   = pix_b_q;
    m_data_d  = m_data_q;
    m_comp_d  = m_comp_q;
    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          pix_r_d = bus.s_r;
          pix_g_d = bus.s_g;
          pix_b_d = bus.s_b;
          mode_d  = bus.chroma_en;
          comp_d  = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dp_ready) begin
          state_d = WAIT;
        end else if (wdog_expired) begin
          blk_idx_d = blk_idx_q + 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT: begin
        if (bus.dp_out_valid) begin
          m_data_d = bus.dp_out_data;
          m_comp_d = comp_q;
          state_d  = EMIT;
        end else if (wdog_expired) begin
          blk_idx_d = blk_idx_q + 1'b1;
          state_d   = IDLE;
        end
      end
      EMIT: begin
        if (bus.m_ready) begin
          if (last_comp) begin
            blk_idx_d = blk_idx_q + 1'b1;
            state_d   = IDLE;
          end else begin
            comp_d  = comp_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      comp_q    <= 2'd0;
      mode_q    <= 1'b0;
      blk_idx_q <= '0;
      pix_r_q   <= '0;
      pix_g_q   <= '0;
      pix_b_q   <= '0;
      m_data_q  <= '0;
      m_comp_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      comp_q    <= comp_d;
      mode_q    <= mode_d;
      blk_idx_q <= blk_idx_d;
      pix_r_q   <= pix_r_d;
      pix_g_q   <= pix_g_d;
      pix_b_q   <= pix_b_d;
      m_data_q  <= m_data_d;
      m_comp_q  <= m_comp_d;
    end
  end

  // comp_q only moves on accept or on leaving EMIT, so dp_comp_sel is stable
  // from ISSUE entry until the result is captured.
  assign bus.s_ready      = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.dp_valid     = (state_q == ISSUE);
  assign bus.dp_r         = pix_r_q;
  assign bus.dp_g         = pix_g_q;
  assign bus.dp_b         = pix_b_q;
  assign bus.dp_comp_sel  = comp_q;
  assign bus.dp_out_ready = (state_q != EMIT);
  assign bus.m_valid      = (state_q == EMIT);
  assign bus.m_data       = m_data_q;
  assign bus.m_comp       = m_comp_q;
  assign bus.m_blk_idx    = blk_idx_q;
  assign bus.m_last       = (state_q == EMIT) && last_comp;
endmodule

// File: tb/tb_ycbcr_dct_sequencer.sv
// tb_ycbcr_dct_sequencer
//   Directed, self-checking bench for ycbcr_dct_sequencer. A behavioural
//   datapath answers each request after dpLatency cycles with a value derived
//   from the pixels and the requested component. Expected output beats are
//   queued when a block is offered and popped as the sequencer emits them.
//   Build with YCBCR_SEQ_WATCHDOG_EN to include the watchdog scenario.
module tb_ycbcr_dct_sequencer;
  localparam int IW = 8;
  localparam int PC = 64;
  localparam int FPL = 32;
  localparam int BW = 2;
  localparam int WD = 16;
  localparam int PW = IW * PC;
  localparam int DW = 64 * FPL;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    comp;
    logic [BW-1:0] blk;
    logic          last;
  } beat_t;

  logic clk;
  logic rst_n;
  beat_t sb[$];
  int passCount = 0;
  int checkCount = 0;
  int dpLatency = 20;
  logic dpMute = 1'b0;
  logic [BW-1:0] expBlk = '0;

  ycbcr_dct_sequencer_if #(.INPUT_WIDTH(IW), .PIXEL_COUNT(PC),
    .FIXED_POINT_LENGTH(FPL), .BLK_IDX_W(BW)) bus ();

  ycbcr_dct_sequencer #(.INPUT_WIDTH(IW), .PIXEL_COUNT(PC), .FIXED_POINT_LENGTH(FPL),
    .BLK_IDX_W(BW), .WDOG_CYCLES(WD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runaway guard so the bench always ends
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Stand-in datapath result: depends on every pixel and the component
  function automatic logic [DW-1:0] dpModel(input logic [PW-1:0] r, input logic [PW-1:0] g,
                                            input logic [PW-1:0] b, input logic [1:0] c);
    logic [DW-1:0] d;
    int v;
    for (int k = 0; k < PC; k++) begin
      v = int'(r[k*IW +: IW]) * (int'(c) + 1) + int'(g[k*IW +: IW]) * 7
          - int'(b[k*IW +: IW]) * 13 - k * (int'(c) + 3);
      d[k*FPL +: FPL] = v;
    end
    return d;
  endfunction

  function automatic logic [PW-1:0] randPix();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic checkData(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
  endtask

  task automatic checkPix(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
  endtask

  task automatic checkResetValues(input string tag);
    checkBit({tag, "_s_ready"}, bus.s_ready, 1'b1);
    checkBit({tag, "_busy"}, bus.busy, 1'b0);
    checkBit({tag, "_dp_valid"}, bus.dp_valid, 1'b0);
    checkBit({tag, "_m_valid"}, bus.m_valid, 1'b0);
    checkBit({tag, "_m_last"}, bus.m_last, 1'b0);
    checkBit({tag, "_err_timeout"}, bus.err_timeout, 1'b0);
    checkOutput({tag, "_dp_comp_sel"}, 32'(bus.dp_comp_sel), 32'd0);
    checkOutput({tag, "_m_comp"}, 32'(bus.m_comp), 32'd0);
    checkOutput({tag, "_m_blk_idx"}, 32'(bus.m_blk_idx), 32'd0);
    checkData({tag, "_m_data"}, bus.m_data, '0);
    checkPix({tag, "_dp_r"}, bus.dp_r, '0);
  endtask

  // Offers one block; expected beats are queued unless the block is expected to be dropped
  task automatic applyStimulus(input logic [PW-1:0] r, input logic [PW-1:0] g,
                               input logic [PW-1:0] b, input logic chroma, input logic expectOut);
    int n = 0;
    while (!bus.s_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    checkBit("accept_ready_wait", n < 500, 1'b1);
    if (expectOut) begin
      for (int c = 0; c < (chroma ? 3 : 1); c++) begin
        sb.push_back('{data: dpModel(r, g, b, 2'(c)), comp: 2'(c), blk: expBlk,
                       last: chroma ? (c == 2) : 1'b1});
      end
    end
    expBlk++;
    bus.s_r = r; bus.s_g = g; bus.s_b = b;
    bus.chroma_en = chroma;
    bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_r = randPix(); bus.s_g = randPix(); bus.s_b = randPix();
    bus.chroma_en = ~chroma;
    checkBit("dp_valid_after_accept", bus.dp_valid, 1'b1);
    checkBit("s_ready_after_accept", bus.s_ready, 1'b0);
  endtask

  // Waits for the last beat handshake, then expects s_ready the next cycle
  task automatic waitBlockDone(input string tag);
    int n = 0;
    logic done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk); n++;
      done = bus.m_valid && bus.m_ready && bus.m_last;
    end
    checkBit({tag, "_done"}, done, 1'b1);
    checkBit({tag, "_s_ready_in_emit"}, bus.s_ready, 1'b0);
    @(posedge clk); #1;
    checkBit({tag, "_s_ready_next"}, bus.s_ready, 1'b1);
    checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Behavioural datapath
  initial begin
    logic [PW-1:0] reqR, reqG, reqB;
    logic [1:0] reqComp;
    int n;
    bus.dp_out_valid = 1'b0;
    bus.dp_out_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.dp_valid && bus.dp_ready && !dpMute) begin
        reqR = bus.dp_r; reqG = bus.dp_g; reqB = bus.dp_b;
        reqComp = bus.dp_comp_sel;
        @(posedge clk);
        repeat (dpLatency - 1) @(posedge clk);
        #1;
        if (rst_n && sb.size() != 0)
          checkOutput("dp_comp_sel_hold", 32'(bus.dp_comp_sel), 32'(sb[0].comp));
        bus.dp_out_valid = 1'b1;
        bus.dp_out_data = dpModel(reqR, reqG, reqB, reqComp);
        n = 0;
        do begin
          @(negedge clk); n++;
        end while (!bus.dp_out_ready && n < 1000);
        @(posedge clk); #1;
        bus.dp_out_valid = 1'b0;
      end
    end
  end

  // Scoreboard monitor: compares each accepted downstream beat
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_valid && bus.m_ready) begin
        checkBit("beat_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("m_comp", 32'(bus.m_comp), 32'(e.comp));
          checkOutput("m_blk_idx", 32'(bus.m_blk_idx), 32'(e.blk));
          checkBit("m_last", bus.m_last, e.last);
          checkData("m_data", bus.m_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [PW-1:0] pr, pg, pb;
    int n;
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_r = '0; bus.s_g = '0; bus.s_b = '0;
    bus.chroma_en = 1'b0; bus.dp_ready = 1'b1; bus.m_ready = 1'b1;
    #1;
    checkResetValues("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkBit("s_ready_after_release", bus.s_ready, 1'b1);

    $display("[TB] full block, chroma on, latency 20");
    dpLatency = 20;
    applyStimulus(randPix(), randPix(), randPix(), 1'b1, 1'b1);
    waitBlockDone("blk_chroma");

    $display("[TB] luma-only block");
    dpLatency = 3;
    applyStimulus(randPix(), randPix(), randPix(), 1'b0, 1'b1);
    waitBlockDone("blk_luma");

    $display("[TB] downstream backpressure");
    bus.m_ready = 1'b0;
    applyStimulus(randPix(), randPix(), randPix(), 1'b1, 1'b1);
    n = 0;
    while (!bus.m_valid && n < 500) begin
      @(negedge clk); n++;
    end
    checkBit("bp_m_valid_seen", bus.m_valid, 1'b1);
    repeat (10) begin
      @(negedge clk);
      checkBit("bp_m_valid_hold", bus.m_valid, 1'b1);
      checkData("bp_m_data_hold", bus.m_data, sb[0].data);
      checkOutput("bp_m_comp_hold", 32'(bus.m_comp), 32'(sb[0].comp));
      checkBit("bp_dp_out_ready", bus.dp_out_ready, 1'b0);
      checkBit("bp_no_dp_valid", bus.dp_valid, 1'b0);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    waitBlockDone("blk_bp");

    $display("[TB] datapath request stall");
    pr = randPix(); pg = randPix(); pb = randPix();
    bus.dp_ready = 1'b0;
    applyStimulus(pr, pg, pb, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      checkBit("stall_dp_valid", bus.dp_valid, 1'b1);
      checkPix("stall_dp_r", bus.dp_r, pr);
      checkPix("stall_dp_g", bus.dp_g, pg);
      checkPix("stall_dp_b", bus.dp_b, pb);
      checkOutput("stall_dp_comp_sel", 32'(bus.dp_comp_sel), 32'd0);
    end
    @(posedge clk); #1;
    bus.dp_ready = 1'b1;
    waitBlockDone("blk_stall");

    $display("[TB] block index wrap");
    dpLatency = 1;
    applyStimulus(randPix(), randPix(), randPix(), 1'b0, 1'b1);
    waitBlockDone("blk_wrap");

    $display("[TB] reset during WAIT");
    dpLatency = 20;
    applyStimulus(randPix(), randPix(), randPix(), 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    sb.delete();
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_reset");
    expBlk = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkBit("s_ready_after_mid_reset", bus.s_ready, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    dpLatency = 4;
    applyStimulus(randPix(), randPix(), randPix(), 1'b1, 1'b1);
    waitBlockDone("blk_after_reset");

`ifdef YCBCR_SEQ_WATCHDOG_EN
    $display("[TB] watchdog with silent datapath");
    @(negedge clk);
    rst_n = 1'b0;
    expBlk = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dpMute = 1'b1;
    applyStimulus(randPix(), randPix(), randPix(), 1'b1, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    checkBit("wdog_err_before_limit", bus.err_timeout, 1'b0);
    checkBit("wdog_busy_before_limit", bus.busy, 1'b1);
    @(posedge clk); #1;
    checkBit("wdog_err_at_limit", bus.err_timeout, 1'b1);
    checkBit("wdog_idle_at_limit", bus.busy, 1'b0);
    checkBit("wdog_no_m_valid", bus.m_valid, 1'b0);
    dpMute = 1'b0;
    applyStimulus(randPix(), randPix(), randPix(), 1'b0, 1'b1);
    waitBlockDone("blk_after_wdog");
    checkBit("wdog_err_sticky", bus.err_timeout, 1'b1);
`else
    checkBit("err_timeout_tied_low", bus.err_timeout, 1'b0);
`endif

    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
